// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// CPU word port on one side; 4-word block read/write bus to memory on the other.
module d_cache_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int INDEX_BITS  = 2,
  parameter int MEM_LATENCY = 2,
  parameter int BANDWIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_read,
  input  logic                 c_write,
  input  logic [WORD_SIZE-1:0] c_address,
  input  logic [WORD_SIZE-1:0] c_wdata,
  output logic [WORD_SIZE-1:0] c_rdata,
  output logic                 c_ready,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  inout  wire  [BANDWIDTH-1:0] m_data,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
  output logic [1:0]           dbg_state
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - 2;
  localparam int CNT_W    = $clog2(MEM_LATENCY) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]     lat_cnt;
  logic                 last;
  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [WORD_SIZE-1:0] line_q [LINES][4];
  logic [WORD_SIZE-1:0] req_addr_q, addr_sel;
  logic [BANDWIDTH-1:0] wb_block;

  logic [TAG_BITS-1:0]   c_tag, a_tag, r_tag;
  logic [INDEX_BITS-1:0] c_idx, a_idx, r_idx;
  logic [1:0]            c_off;
  logic                  req, hit, miss;

  assign c_tag = c_address[WORD_SIZE-1:INDEX_BITS+2];
  assign c_idx = c_address[INDEX_BITS+1:2];
  assign c_off = c_address[1:0];
  assign r_tag = req_addr_q[WORD_SIZE-1:INDEX_BITS+2];
  assign r_idx = req_addr_q[INDEX_BITS+1:2];

  // In IDLE the miss address is still on the CPU port; afterwards it is latched.
  assign addr_sel = (state_q == IDLE) ? c_address : req_addr_q;
  assign a_tag    = addr_sel[WORD_SIZE-1:INDEX_BITS+2];
  assign a_idx    = addr_sel[INDEX_BITS+1:2];

  assign req     = c_read | c_write;
  assign hit     = (state_q == IDLE) && req && valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign miss    = (state_q == IDLE) && req && !hit;
  assign c_ready = hit;
  assign c_rdata = line_q[c_idx][c_off];
  assign last    = (lat_cnt == CNT_W'(MEM_LATENCY - 1));
  assign dbg_state = state_q;

  always_comb begin
    wb_block = '0;
    for (int k = 0; k < 4; k++)
      wb_block[BANDWIDTH-1-k*WORD_SIZE -: WORD_SIZE] = line_q[r_idx][k];
  end

  assign m_data = m_writeM ? wb_block : 'z;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = (valid_q[c_idx] && dirty_q[c_idx]) ? WB : FILL;
      WB:      if (last) state_d = FILL;
      FILL:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lat_cnt    <= '0;
      m_readM    <= 1'b0;
      m_writeM   <= 1'b0;
      m_address  <= '0;
      req_addr_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      lat_cnt  <= (state_d != state_q) ? '0 : lat_cnt + CNT_W'(1);
      // Strobes come straight from the next state so WB->FILL hands over without a gap.
      m_readM  <= (state_d == FILL);
      m_writeM <= (state_d == WB);
      case (state_d)
        WB:      m_address <= {tag_q[a_idx], a_idx, 2'b00};
        FILL:    m_address <= {a_tag, a_idx, 2'b00};
        default: m_address <= '0;
      endcase
      if (miss) begin
        req_addr_q <= c_address;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        if (c_write) dirty_q[c_idx] <= 1'b1;
      end
      if (state_q == WB && last) dirty_q[r_idx] <= 1'b0;
      if (state_q == FILL && last) begin
        valid_q[r_idx] <= 1'b1;
        dirty_q[r_idx] <= 1'b0;
        tag_q[r_idx]   <= r_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit && c_write) line_q[c_idx][c_off] <= c_wdata;
    if (state_q == FILL && last)
      for (int k = 0; k < 4; k++)
        line_q[r_idx][k] <= m_data[BANDWIDTH-1-k*WORD_SIZE -: WORD_SIZE];
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Bench for d_cache_ctrl: behavioural memory on the block bus, a flat golden
// memory plus line tag/valid/dirty model predicting hits, latency and data.
module tb_d_cache_ctrl;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        reset_n, c_read, c_write;
  logic [15:0] c_address, c_wdata;
  wire  [15:0] c_rdata, m_address, hit_count, miss_count;
  wire         c_ready, m_readM, m_writeM;
  wire  [63:0] m_data;
  wire  [1:0]  dbg_state;

  d_cache_ctrl #(.WORD_SIZE(16), .INDEX_BITS(2), .MEM_LATENCY(ML), .BANDWIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .c_read(c_read), .c_write(c_write),
    .c_address(c_address), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_data(m_data),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model: 256 words, block reads driven while m_readM, writes taken while m_writeM.
  logic [15:0] mem  [256];
  logic [15:0] gold [256];
  logic [7:0]  mbase;
  logic [63:0] mem_drive;
  assign mbase = {m_address[7:2], 2'b00};
  always_comb mem_drive = {mem[mbase], mem[mbase + 8'd1], mem[mbase + 8'd2], mem[mbase + 8'd3]};
  assign m_data = m_readM ? mem_drive : 'z;
  always @(posedge clk)
    if (m_writeM) begin
      mem[mbase]        <= m_data[63:48];
      mem[mbase + 8'd1] <= m_data[47:32];
      mem[mbase + 8'd2] <= m_data[31:16];
      mem[mbase + 8'd3] <= m_data[15:0];
    end

  // Reference cache state
  logic       ref_valid [4];
  logic       ref_dirty [4];
  logic [3:0] ref_tag   [4];
  int exp_hits, exp_misses;
  int passes = 0, total = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = 0; end
    exp_hits = 0; exp_misses = 0;
  endtask

  task automatic check_counters();
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask

  // One CPU access; drop=1 withdraws the request in cycle 1 of a miss.
  task automatic access(input bit rd, input bit wr, input logic [7:0] addr,
                        input logic [15:0] wd, input bit drop);
    logic [1:0]  idx;
    logic [3:0]  tag;
    logic [7:0]  vb;
    logic [63:0] exp_wb;
    logic [15:0] rdata_seen;
    bit is_hit, is_dirty, got, both, wb_ok, addr_ok, late_ready;
    int exp_lat, cyc, n_wr, n_rd;
    idx = addr[3:2];
    tag = addr[7:4];
    is_hit   = ref_valid[idx] && ref_tag[idx] == tag;
    is_dirty = !is_hit && ref_valid[idx] && ref_dirty[idx];
    vb       = {ref_tag[idx], idx, 2'b00};
    exp_wb   = {gold[vb], gold[vb + 8'd1], gold[vb + 8'd2], gold[vb + 8'd3]};
    exp_lat  = is_hit ? 0 : (is_dirty ? 2 * ML + 1 : ML + 1);
    @(negedge clk);
    c_read = rd; c_write = wr; c_address = {8'h00, addr}; c_wdata = wd;
    cyc = 0; got = 0; both = 0; wb_ok = 1; addr_ok = 1; late_ready = 0;
    n_wr = 0; n_rd = 0; rdata_seen = '0;
    while (cyc < 20 && !(drop && cyc > exp_lat)) begin
      #1;
      if (m_readM && m_writeM) both = 1;
      if (m_writeM) begin
        n_wr++;
        if (m_address !== {8'h00, vb} || m_data !== exp_wb) wb_ok = 0;
      end
      if (m_readM) begin
        n_rd++;
        if (m_address !== {8'h00, tag, idx, 2'b00}) addr_ok = 0;
      end
      if (drop && cyc >= 1 && c_ready) late_ready = 1;
      if (!drop && c_ready) begin got = 1; rdata_seen = c_rdata; break; end
      if (drop && cyc == 1) begin c_read = 0; c_write = 0; end
      @(negedge clk);
      cyc++;
    end
    if (!drop) begin
      check("ready_seen", got, 1);
      check("latency", cyc, exp_lat);
      if (rd && !wr) check("rdata", rdata_seen, gold[addr]);
    end else begin
      check("no_ready_after_drop", late_ready, 0);
    end
    check("wb_cycles", n_wr, is_dirty ? ML : 0);
    check("fill_cycles", n_rd, is_hit ? 0 : ML);
    check("wb_addr_data", wb_ok, 1);
    check("fill_addr", addr_ok, 1);
    check("strobe_overlap", both, 0);
    if (!is_hit) begin
      if (exp_misses != 65535) exp_misses++;
      ref_valid[idx] = 1; ref_dirty[idx] = 0; ref_tag[idx] = tag;
    end
    if (!drop) begin
      if (exp_hits != 65535) exp_hits++;
      if (wr) begin gold[addr] = wd; ref_dirty[idx] = 1; end
    end
    @(negedge clk);
    c_read = 0; c_write = 0;
    #1;
    check_counters();
  endtask

  initial begin
    logic [7:0] ra;
    int op;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h23] = 16'h6000;
    mem[8'h24] = 16'hF01C;
    for (int i = 0; i < 256; i++) gold[i] = mem[i];
    ref_reset();
    reset_n = 0; c_read = 0; c_write = 0; c_address = '0; c_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_readM", m_readM, 0);
    check("rst_m_writeM", m_writeM, 0);
    check("rst_m_address", m_address, 0);
    check("rst_c_ready", c_ready, 0);
    check("rst_state", dbg_state, 2'd0);
    check_counters();
    reset_n = 1;

    // Clean miss, hit in the same block, miss into a second block
    access(1, 0, 8'h23, 16'h0, 0);
    access(1, 0, 8'h21, 16'h0, 0);
    access(1, 0, 8'h24, 16'h0, 0);
    check("f01c_word", gold[8'h24], 16'hF01C);

    // Dirty eviction of block 0x20 by 0x31
    access(0, 1, 8'h21, 16'hABCD, 0);
    access(1, 0, 8'h31, 16'h0, 0);
    check("wb_word_in_mem", mem[8'h21], 16'hABCD);

    // Reset in the middle of a fill of an unused line
    @(negedge clk);
    c_read = 1; c_address = 16'h0048;
    @(negedge clk);
    #1;
    check("fill_started", m_readM, 1);
    reset_n = 0;
    @(negedge clk);
    c_read = 0;
    #1;
    check("rst_fill_m_readM", m_readM, 0);
    check("rst_fill_state", dbg_state, 2'd0);
    @(negedge clk);
    reset_n = 1;
    ref_reset();
    for (int i = 0; i < 256; i++) gold[i] = mem[i];
    #1;
    check_counters();
    access(1, 0, 8'h48, 16'h0, 0);

    // Dropped request still installs the line
    access(1, 0, 8'h58, 16'h0, 1);
    access(1, 0, 8'h5A, 16'h0, 0);

    // Randomised traffic, including read+write together and drops
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom_range(0, 255));
      op = $urandom_range(0, 7);
      if (op == 7 && !(ref_valid[ra[3:2]] && ref_tag[ra[3:2]] == ra[7:4]))
        access(1, 0, ra, 16'h0, 1);
      else if (op >= 5)
        access(op == 6, 1, ra, 16'($urandom), 0);
      else
        access(1, 0, ra, 16'h0, 0);
    end

    // Saturation of the hit counter with a continuously held hit
    access(1, 0, 8'h10, 16'h0, 0);
    @(negedge clk);
    c_read = 1; c_address = 16'h0010;
    repeat (65540) @(negedge clk);
    c_read = 0;
    exp_hits = 65535;
    #1;
    check_counters();
    access(1, 0, 8'h11, 16'h0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
